// File: rtl/log_frame_normalizer.sv
// log_frame_normalizer
// Captures one frame of packed unsigned log-energies, sums them serially,
// divides by the filter count with a restoring divider, then streams the
// mean-removed signed coefficients over a valid/ready handshake.
// Optional build macro: LOGNORM_MEAN_OUT_EN appends one extra word carrying the
// frame mean (zero-extended) after the last coefficient.
module log_frame_normalizer #(
  parameter  int N_FILTERS = 40,
  parameter  int IN_WIDTH  = 6,
  parameter  int OUT_WIDTH = 7,
  localparam int SUM_WIDTH = IN_WIDTH + $clog2(N_FILTERS),
  localparam int IDX_WIDTH = $clog2(N_FILTERS + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [IN_WIDTH*N_FILTERS-1:0] log_energy_flat,
  output logic                          busy,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [OUT_WIDTH-1:0]   out_data,
  output logic [IDX_WIDTH-1:0]          out_index,
  output logic                          out_last,
  output logic                          done
);

  localparam int DIV_CNT_WIDTH = $clog2(SUM_WIDTH);
  localparam int CNT_WIDTH     = (IDX_WIDTH > DIV_CNT_WIDTH) ? IDX_WIDTH : DIV_CNT_WIDTH;
`ifdef LOGNORM_MEAN_OUT_EN
  localparam int LAST_IDX = N_FILTERS;
`else
  localparam int LAST_IDX = N_FILTERS - 1;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SUM    = 3'd1,
    ST_DIV    = 3'd2,
    ST_STREAM = 3'd3,
    ST_FIN    = 3'd4
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;

  logic [IN_WIDTH-1:0]    frame_r [N_FILTERS];
  logic [SUM_WIDTH-1:0]   acc_r;
  logic [SUM_WIDTH-1:0]   quot_r;
  logic [SUM_WIDTH-1:0]   rem_r;
  logic [IN_WIDTH-1:0]    mean_r;
  logic [CNT_WIDTH-1:0]   cnt_r;

  logic                   busy_r;
  logic                   out_valid_r;
  logic [OUT_WIDTH-1:0]   out_data_r;
  logic [IDX_WIDTH-1:0]   out_index_r;
  logic                   out_last_r;
  logic                   done_r;

  logic                   sum_last_s;
  logic                   div_last_s;
  logic                   xfer_last_s;
  logic [SUM_WIDTH-1:0]   acc_nxt_s;
  logic [SUM_WIDTH:0]     shift_s;
  logic [SUM_WIDTH:0]     trial_s;
  logic                   div_ok_s;
  logic [SUM_WIDTH-1:0]   rem_nxt_s;
  logic [SUM_WIDTH-1:0]   quot_nxt_s;
  logic [IDX_WIDTH-1:0]   sel_idx_s;
  logic [IDX_WIDTH-1:0]   elem_idx_s;
  logic [OUT_WIDTH-1:0]   word_s;
  logic                   last_s;

  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_index = out_index_r;
  assign out_last  = out_last_r;
  assign done      = done_r;

  // Phase-end flags, accumulator adder and one restoring-division step.
  always_comb begin
    sum_last_s  = (cnt_r == CNT_WIDTH'(N_FILTERS - 1));
    div_last_s  = (cnt_r == CNT_WIDTH'(SUM_WIDTH - 1));
    xfer_last_s = out_valid_r & out_ready & out_last_r;
    acc_nxt_s   = acc_r + SUM_WIDTH'(frame_r[cnt_r[IDX_WIDTH-1:0]]);
    // Remainder is always below N_FILTERS, so the borrow bit of the trial
    // subtraction alone tells whether the divisor fits.
    shift_s     = {rem_r, quot_r[SUM_WIDTH-1]};
    trial_s     = shift_s - {1'b0, SUM_WIDTH'(N_FILTERS)};
    div_ok_s    = ~trial_s[SUM_WIDTH];
    if (div_ok_s) begin
      rem_nxt_s = trial_s[SUM_WIDTH-1:0];
    end else begin
      rem_nxt_s = shift_s[SUM_WIDTH-1:0];
    end
    quot_nxt_s  = {quot_r[SUM_WIDTH-2:0], div_ok_s};
  end

  // Select the word to present next and form its coefficient.
  always_comb begin
    if (out_valid_r) begin
      sel_idx_s = out_index_r + IDX_WIDTH'(1'b1);
    end else begin
      sel_idx_s = out_index_r;
    end
    if (sel_idx_s < IDX_WIDTH'(N_FILTERS)) begin
      elem_idx_s = sel_idx_s;
    end else begin
      elem_idx_s = {IDX_WIDTH{1'b0}};
    end
`ifdef LOGNORM_MEAN_OUT_EN
    if (sel_idx_s == IDX_WIDTH'(N_FILTERS)) begin
      word_s = OUT_WIDTH'(mean_r);
    end else begin
      word_s = OUT_WIDTH'(frame_r[elem_idx_s]) - OUT_WIDTH'(mean_r);
    end
`else
    word_s = OUT_WIDTH'(frame_r[elem_idx_s]) - OUT_WIDTH'(mean_r);
`endif
    last_s = (sel_idx_s == IDX_WIDTH'(LAST_IDX));
  end

  // Next-state logic for the capture/sum/divide/stream sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_SUM;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SUM: begin
        if (sum_last_s) begin
          state_nxt_s = ST_DIV;
        end else begin
          state_nxt_s = ST_SUM;
        end
      end
      ST_DIV: begin
        if (div_last_s) begin
          state_nxt_s = ST_STREAM;
        end else begin
          state_nxt_s = ST_DIV;
        end
      end
      ST_STREAM: begin
        if (xfer_last_s) begin
          state_nxt_s = ST_FIN;
        end else begin
          state_nxt_s = ST_STREAM;
        end
      end
      ST_FIN:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register; reset abandons any frame in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Frame buffer: snapshot of the inputs taken on the accepted start edge only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_FILTERS; i++) begin
        frame_r[i] <= {IN_WIDTH{1'b0}};
      end
    end else if ((state_r == ST_IDLE) && start) begin
      for (int i = 0; i < N_FILTERS; i++) begin
        frame_r[i] <= log_energy_flat[i*IN_WIDTH +: IN_WIDTH];
      end
    end
  end

  // Serial accumulation and restoring division producing the frame mean.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r  <= {SUM_WIDTH{1'b0}};
      quot_r <= {SUM_WIDTH{1'b0}};
      rem_r  <= {SUM_WIDTH{1'b0}};
      mean_r <= {IN_WIDTH{1'b0}};
      cnt_r  <= {CNT_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            acc_r <= {SUM_WIDTH{1'b0}};
            cnt_r <= {CNT_WIDTH{1'b0}};
          end
        end
        ST_SUM: begin
          acc_r <= acc_nxt_s;
          if (sum_last_s) begin
            quot_r <= acc_nxt_s;
            rem_r  <= {SUM_WIDTH{1'b0}};
            cnt_r  <= {CNT_WIDTH{1'b0}};
          end else begin
            cnt_r  <= cnt_r + CNT_WIDTH'(1'b1);
          end
        end
        ST_DIV: begin
          quot_r <= quot_nxt_s;
          rem_r  <= rem_nxt_s;
          if (div_last_s) begin
            mean_r <= quot_nxt_s[IN_WIDTH-1:0];
            cnt_r  <= {CNT_WIDTH{1'b0}};
          end else begin
            cnt_r  <= cnt_r + CNT_WIDTH'(1'b1);
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Registered stream outputs plus busy/done status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {OUT_WIDTH{1'b0}};
      out_index_r <= {IDX_WIDTH{1'b0}};
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != ST_IDLE);
      done_r <= (state_nxt_s == ST_FIN);
      if (state_r == ST_STREAM) begin
        if (!out_valid_r) begin
          out_valid_r <= 1'b1;
          out_data_r  <= word_s;
          out_index_r <= sel_idx_s;
          out_last_r  <= last_s;
        end else if (out_ready) begin
          if (out_last_r) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {OUT_WIDTH{1'b0}};
            out_index_r <= {IDX_WIDTH{1'b0}};
            out_last_r  <= 1'b0;
          end else begin
            out_data_r  <= word_s;
            out_index_r <= sel_idx_s;
            out_last_r  <= last_s;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_log_frame_normalizer.sv
// Scoreboard bench for log_frame_normalizer: frames are driven with random
// data and random downstream backpressure; a reference model computes each
// frame's mean with integer division and queues the expected words, and an
// independent monitor pops and compares every accepted word.
module tb_log_frame_normalizer;
  localparam int N    = 40;
  localparam int IW   = 6;
  localparam int OW   = 7;
  localparam int IDXW = 6;
  localparam int LATENCY = 1 + N + IW + $clog2(N);
`ifdef LOGNORM_MEAN_OUT_EN
  localparam int NWORDS = N + 1;
`else
  localparam int NWORDS = N;
`endif

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [IW*N-1:0]   log_energy_flat;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [OW-1:0]     out_data;
  logic [IDXW-1:0]   out_index;
  logic              out_last;
  logic              done;

  typedef struct {
    logic [OW-1:0]   data;
    logic [IDXW-1:0] idx;
    logic            last;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   ready_pct = 100;
  int   stall_left = 0;

  log_frame_normalizer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .log_energy_flat (log_energy_flat),
    .busy            (busy),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_index       (out_index),
    .out_last        (out_last),
    .done            (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: frame mean by integer division, then x - mean per word.
  task automatic push_frame(input logic [IW*N-1:0] flat);
    int   sum;
    int   mean;
    int   x;
    exp_t e;
    sum = 0;
    for (int i = 0; i < N; i++) sum += int'(flat[i*IW +: IW]);
    mean = sum / N;
    for (int i = 0; i < N; i++) begin
      x      = int'(flat[i*IW +: IW]);
      e.data = OW'(x - mean);
      e.idx  = IDXW'(i);
      e.last = (i == NWORDS - 1);
      sb.push_back(e);
    end
`ifdef LOGNORM_MEAN_OUT_EN
    e.data = OW'(mean);
    e.idx  = IDXW'(N);
    e.last = 1'b1;
    sb.push_back(e);
`endif
  endtask

  function automatic logic [IW*N-1:0] rand_frame();
    logic [IW*N-1:0] f;
    for (int i = 0; i < N; i++) f[i*IW +: IW] = IW'($urandom);
    return f;
  endfunction

  function automatic logic [IW*N-1:0] const_frame(input int v);
    logic [IW*N-1:0] f;
    for (int i = 0; i < N; i++) f[i*IW +: IW] = IW'(v);
    return f;
  endfunction

  // Called at #1 after the capture edge; counts edges to the first out_valid.
  task automatic check_latency(input string name);
    int n;
    n = 0;
    for (int k = 1; k <= 200 && n == 0; k++) begin
      @(posedge clk); #1;
      if (out_valid) n = k;
    end
    check({name, "_latency"}, n, LATENCY);
  endtask

  task automatic wait_done(input string name);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 2000 && !got; k++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check({name, "_done_seen"}, got, 1);
    check({name, "_drained"}, sb.size(), 0);
  endtask

  task automatic run_frame(input logic [IW*N-1:0] flat, input string name);
    @(negedge clk);
    log_energy_flat = flat;
    start = 1'b1;
    push_frame(flat);
    @(posedge clk); #1;
    start = 1'b0;
    log_energy_flat = rand_frame();
    check_latency(name);
    wait_done(name);
  endtask

  // Downstream ready: random acceptance, plus a forced stall on index 3.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (stall_left > 0 && out_valid && out_index == 6'd3) begin
        out_ready = 1'b0;
        stall_left--;
      end else if (ready_pct >= 100) begin
        out_ready = 1'b1;
      end else begin
        out_ready = ($urandom_range(0, 99) < ready_pct);
      end
    end
  end

  // Monitor: compares accepted words, stall stability and the done pulse.
  logic [OW-1:0]   prev_data;
  logic [IDXW-1:0] prev_idx;
  logic            prev_last;
  bit              have_prev = 1'b0;
  bit              pend_done = 1'b0;
  exp_t            got_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      have_prev = 1'b0;
      pend_done = 1'b0;
    end else begin
      if (pend_done || done) check("done_pulse", done, pend_done);
      pend_done = 1'b0;
      if (have_prev) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_data);
        check("stall_index", out_index, prev_idx);
        check("stall_last", out_last, prev_last);
      end
      have_prev = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_word: actual=index %0d required=no word", out_index);
          end else begin
            got_e = sb.pop_front();
            check("word_data", out_data, got_e.data);
            check("word_index", out_index, got_e.idx);
            check("word_last", out_last, got_e.last);
            if (out_last) pend_done = 1'b1;
          end
        end else begin
          have_prev = 1'b1;
          prev_data = out_data;
          prev_idx  = out_index;
          prev_last = out_last;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [IW*N-1:0] fa;
    logic [IW*N-1:0] fb;
    bit              found;
    int              dcount;
    rst_n = 1'b0;
    start = 1'b0;
    log_energy_flat = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_done", done, 0);
    check("rst_data", out_data, 0);
    check("rst_index", out_index, 0);
    rst_n = 1'b1;

    // Ramp frame: mean 19.
    ready_pct = 80;
    for (int i = 0; i < N; i++) fa[i*IW +: IW] = IW'(i);
    run_frame(fa, "ramp");

    // Single spike: mean 1.
    fa = '0;
    fa[5*IW +: IW] = 6'd63;
    run_frame(fa, "spike");

    // Backpressure with a 5-cycle stall on index 3.
    ready_pct  = 60;
    stall_left = 5;
    run_frame(rand_frame(), "backpressure");
    check("stall_consumed", stall_left, 0);

    // Boundaries.
    ready_pct = 100;
    run_frame(const_frame(0), "all_zero");
    run_frame(const_frame(63), "all_max");

    // start held high across a frame while the inputs change.
    ready_pct = 75;
    fa = rand_frame();
    fb = rand_frame();
    @(negedge clk);
    log_energy_flat = fa;
    start = 1'b1;
    push_frame(fa);
    @(posedge clk); #1;
    log_energy_flat = fb;
    check_latency("hold_a");
    wait_done("hold_a");
    check("hold_fin_busy", busy, 1);
    push_frame(fb);
    @(posedge clk); #1;
    check("hold_idle_busy", busy, 0);
    @(posedge clk); #1;
    check("hold_restart_busy", busy, 1);
    start = 1'b0;
    log_energy_flat = rand_frame();
    check_latency("hold_b");
    wait_done("hold_b");

    // Reset while index 10 is presented.
    @(negedge clk);
    fa = rand_frame();
    log_energy_flat = fa;
    start = 1'b1;
    push_frame(fa);
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge clk);
      if (out_valid && out_index == 6'd10) found = 1'b1;
    end
    check("reach_index10", found, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_last", out_last, 0);
    check("midrst_done", done, 0);
    check("midrst_data", out_data, 0);
    check("midrst_index", out_index, 0);
    #2;
    rst_n = 1'b1;
    sb.delete();
    dcount = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("midrst_no_done", dcount, 0);
    run_frame(const_frame(20), "after_reset");

    // A few more random frames under random backpressure.
    ready_pct = 50;
    repeat (3) run_frame(rand_frame(), "random");

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/log_frame_normalizer.md
Name: log_frame_normalizer

Overview:
- Sits directly downstream of the log-compression stage in the speech-emotion feature pipeline.
- Captures one frame of N_FILTERS packed log-energies, computes the frame mean over all filters with a sequential divider, then streams mean-removed signed coefficients one per handshake to the classifier front end.
- Suppresses per-frame loudness so downstream features reflect spectral shape rather than absolute level.

Parameters:
- N_FILTERS, 40, number of log-energy values per frame.
- IN_WIDTH, 6, unsigned width of each log-energy value.
- OUT_WIDTH, 7, signed width of each output coefficient. Must be at least IN_WIDTH+1.
- SUM_WIDTH, IN_WIDTH+$clog2(N_FILTERS) (12 by default), accumulator and divider width. Localparam.
- IDX_WIDTH, $clog2(N_FILTERS+1) (6 by default), width of out_index. Localparam.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  synchronous reset, active-low. Sampled on the rising edge of clk.
- start  in  1  frame-available strobe. Sampled only in IDLE.
- log_energy_flat  in  IN_WIDTH*N_FILTERS  packed input. Element i occupies bits [(i+1)*IN_WIDTH-1 -: IN_WIDTH].
- busy  out  1  high in every state except IDLE.
- out_valid  out  1  out_data, out_index and out_last are valid.
- out_ready  in  1  downstream accepts the current word.
- out_data  out  OUT_WIDTH  signed result x[i] minus mean, in two's complement.
- out_index  out  IDX_WIDTH  index of the current word.
- out_last  out  1  marks the final word of the frame.
- done  out  1  one-cycle pulse after the final word is accepted.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE.
  - busy, out_valid, out_last and done are 0; out_data and out_index are 0.
  - Accumulator, divider and mean registers are cleared.
  - Reset takes priority over all other activity, including mid-frame: the frame in progress is discarded and no done pulse is issued.
- FSM states: IDLE, SUM, DIV, STREAM, FIN.
- IDLE:
  - On start=1, all N_FILTERS elements are copied into an internal frame buffer, the accumulator is cleared, and the state goes to SUM.
  - Input changes after the capture edge have no effect on the frame.
- SUM:
  - Adds one buffered element per cycle, in index order, into the SUM_WIDTH accumulator.
  - Lasts exactly N_FILTERS cycles, then goes to DIV.
- DIV:
  - Restoring division sum / N_FILTERS, one quotient bit per cycle.
  - Lasts exactly SUM_WIDTH cycles. The quotient is truncated (floor).
  - mean fits in IN_WIDTH bits. Goes to STREAM.
- STREAM:
  - out_valid rises exactly 1+N_FILTERS+SUM_WIDTH rising edges after the edge that sampled start (53 edges at default parameters).
  - out_data = zero-extended x[i] minus zero-extended mean, computed in OUT_WIDTH bits.
  - Handshake: a word transfers on any edge where out_valid=1 and out_ready=1. The index then advances and the next word is presented in the following cycle, so throughput is 1 word per cycle.
  - While out_valid=1 and out_ready=0, out_data, out_index and out_last hold stable.
  - out_valid never drops before its word transfers.
  - out_last=1 only on index N_FILTERS-1.
  - When the last word transfers, out_valid drops and the state goes to FIN.
- FIN:
  - done=1 for exactly one cycle, then the state returns to IDLE.
  - A start sampled in the cycle after FIN begins a new frame.
- start while busy=1 is ignored; it is neither queued nor able to corrupt the frame.
- out_ready is ignored when out_valid=0.
- Boundaries:
  - All-zero frame: mean=0 and every output is 0.
  - All inputs at maximum: mean equals that maximum and every output is 0.
  - No overflow is possible: sum ≤ N_FILTERS·(2^IN_WIDTH−1) < 2^SUM_WIDTH.

Optional Feature:
- Macro LOGNORM_MEAN_OUT_EN.
- Defined:
  - After word N_FILTERS-1, STREAM emits one extra word at out_index=N_FILTERS whose out_data is the mean, zero-extended.
  - out_last moves to this extra word and is 0 on index N_FILTERS-1.
  - done follows acceptance of the extra word.
- Undefined: exactly N_FILTERS words per frame; no mean word and no extra logic.

Test Plan:
- Ramp, x[i]=i for i=0..39, start pulse: sum 780, mean 19. First out_valid 53 edges after start. out_data[0]=−19 (7'h6D), out_data[19]=0, out_data[39]=+20 with out_last=1. done pulses once.
- x[5]=63, all others 0: mean 1. out_data[5]=+62 and every other word is −1 (7'h7F).
- Backpressure: out_ready=0 for 5 cycles while index 3 is presented, with random out_ready elsewhere. All 40 words arrive in order; data/index are stable while stalled; no word is dropped or duplicated.
- start held high through a whole frame carrying different data: exactly one frame is processed, using the data captured at the first edge. A second frame starts only after the FIN cycle.
- rst_n=0 for one edge when out_index=10: all outputs are 0 the next cycle with no done pulse. A fresh start (all inputs 20) then yields 40 zeros.
- With LOGNORM_MEAN_OUT_EN, ramp frame: 41 words; the word at index 40 has out_data=19 and out_last=1; index 39 has out_last=0.
